result_reader: RTL and testbench

- Read-back engine on the SRAM read port of the matrix datapath.
- After the ALU/write-back pass finishes, walks a contiguous block of result addresses through the read_n/r_addr/ry/data_out interface.
- Buffers each returned 9-bit word in a small FIFO and streams it to the host over a valid/ready handshake.
- It is the reader counterpart of the write-back path that fills the SRAM.

---
 rtl/result_reader_pkg.sv | 19 +
 rtl/result_reader_if.sv | 23 ++
 rtl/result_reader_rd_fifo.sv | 51 +++++
 rtl/result_reader.sv | 115 +++++++++++
 tb/tb_result_reader.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/result_reader_pkg.sv
// Shared defaults and controller state encoding for the SRAM read-back path.
// The write-back block imports the same address/data defaults.
package result_reader_pkg;

  localparam int unsigned DefAddrW    = 8;
  localparam int unsigned DefDataW    = 9;
  localparam int unsigned DefBaseAddr = 0;
  localparam int unsigned DefNumWords = 16;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReq   = 3'd1,
    StWait  = 3'd2,
    StHold  = 3'd3,
    StDrain = 3'd4,
    StDone  = 3'd5
  } state_e;

endpackage

// File: rtl/result_reader_if.sv
// SRAM read port plus host stream handshake; master is the reader side.
interface result_reader_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 9
) ();
  logic              read_n;
  logic [ADDR_W-1:0] r_addr;
  logic              ry;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output read_n, r_addr, out_data, out_valid,
    input  ry, data_out, out_ready
  );

  modport slave (
    input  read_n, r_addr, out_data, out_valid,
    output ry, data_out, out_ready
  );
endinterface

// File: rtl/result_reader_rd_fifo.sv
// First-word-fall-through buffer between the SRAM read port and the host stream.
module rd_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic              almost_full
);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CntW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              wr_en, rd_en;

  // A push on a full FIFO is only taken when a pop frees the slot in the same cycle.
  assign wr_en       = push && (!full || pop);
  assign rd_en       = pop && !empty;
  assign empty       = (count_q == '0);
  assign full        = (count_q == CntW'(DEPTH));
  assign almost_full = (count_q >= CntW'(DEPTH - 1));
  assign dout        = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/result_reader.sv
// Walks a contiguous block of SRAM result addresses after the ALU pass and
// streams the returned words to the host through a small FWFT buffer.
module result_reader
  import result_reader_pkg::*;
#(
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned BASE_ADDR  = DefBaseAddr,
  parameter int unsigned NUM_WORDS  = DefNumWords,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  result_reader_if.master  bus,
  output logic             busy,
  output logic             done,
  output logic             timeout_err
);
  localparam int unsigned CntW  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CntW-1:0]   word_q, word_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic              terr_q, terr_d;

  logic              fifo_push, fifo_pop, fifo_empty, fifo_full, fifo_afull;
  logic [DATA_W-1:0] fifo_dout;

  assign fifo_push = (state_q == StWait) && bus.ry;
  assign fifo_pop  = bus.out_ready && !fifo_empty;

  rd_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_rd_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (fifo_push),
    .din         (bus.data_out),
    .pop         (fifo_pop),
    .dout        (fifo_dout),
    .empty       (fifo_empty),
    .full        (fifo_full),
    .almost_full (fifo_afull)
  );

  assign bus.read_n    = !((state_q == StReq) || (state_q == StWait));
  assign bus.r_addr    = addr_q;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_empty ? '0 : fifo_dout;
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);
  assign timeout_err   = terr_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    wait_d  = wait_q;
    terr_d  = terr_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StReq;
          addr_d  = ADDR_W'(BASE_ADDR);
          word_d  = '0;
          terr_d  = 1'b0;
        end
      end
      StReq: begin
        wait_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        if (bus.ry) begin
          addr_d = addr_q + 1'b1;
          word_d = word_q + 1'b1;
          // Room after this push (a same-cycle pop counts) allows the next request.
          if (word_q == CntW'(NUM_WORDS - 1)) state_d = StDrain;
          else if (!fifo_afull || fifo_pop)   state_d = StReq;
          else                                state_d = StHold;
        end else if (wait_q == WaitW'(TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          state_d = StDrain;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StHold:  if (!fifo_full) state_d = StReq;
      StDrain: if (fifo_empty) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= ADDR_W'(BASE_ADDR);
      word_q  <= '0;
      wait_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      wait_q  <= wait_d;
      terr_q  <= terr_d;
    end
  end
endmodule

// File: tb/tb_result_reader.sv
// Bench for result_reader: two instances (base 0 / 16 words, base 250 / 10 words)
// driven by an SRAM model returning addr+100, checked against expected word lists.
module tb_result_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  logic busy_a, done_a, terr_a, busy_b, done_b, terr_b;

  always #5 clk = ~clk;

  result_reader_if #(.ADDR_W(8), .DATA_W(9)) bus_a ();
  result_reader_if #(.ADDR_W(8), .DATA_W(9)) bus_b ();

  result_reader #(.BASE_ADDR(0), .NUM_WORDS(16)) dut_a (
    .clk         (clk),
    .rst         (rst),
    .start       (start_a),
    .bus         (bus_a),
    .busy        (busy_a),
    .done        (done_a),
    .timeout_err (terr_a)
  );

  result_reader #(.BASE_ADDR(250), .NUM_WORDS(10)) dut_b (
    .clk         (clk),
    .rst         (rst),
    .start       (start_b),
    .bus         (bus_b),
    .busy        (busy_b),
    .done        (done_b),
    .timeout_err (terr_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: the k-th word of a pass is the SRAM content at (base+k) mod 256.
  function automatic logic [8:0] exp_word(input int base, input int k);
    return 9'(((base + k) % 256) + 100);
  endfunction

  function automatic logic [7:0] exp_addr(input int base, input int k);
    return 8'((base + k) % 256);
  endfunction

  // SRAM model state and test controls
  int         age_a = 0, lat_a = 1, age_b = 0;
  bit         was_low_a = 0, was_low_b = 0;
  logic [7:0] last_addr_a = '0, last_addr_b = '0;
  int         stuck_addr = -1;
  bit         rand_mode = 0;
  logic       rdy_a = 1'b1;

  int push_a, pop_a, done_cnt_a, busy_cyc_a, low3_a;
  int push_b, pop_b, done_cnt_b;

  task automatic clear_stats();
    push_a = 0; pop_a = 0; done_cnt_a = 0; busy_cyc_a = 0; low3_a = 0;
    push_b = 0; pop_b = 0; done_cnt_b = 0;
  endtask

  // SRAM: ry once read_n has been low on the same address for lat cycles; ry noise while idle.
  always @(posedge clk) begin
    #1;
    if (!bus_a.read_n && was_low_a && bus_a.r_addr == last_addr_a) age_a++;
    else begin
      age_a = 0;
      lat_a = rand_mode ? int'($urandom_range(1, 3)) : 1;
    end
    was_low_a   = !bus_a.read_n;
    last_addr_a = bus_a.r_addr;
    bus_a.ry    = bus_a.read_n ? 1'($urandom % 2)
                               : (age_a >= lat_a && int'(bus_a.r_addr) != stuck_addr);
    bus_a.data_out  = 9'(bus_a.r_addr) + 9'd100;
    bus_a.out_ready = rand_mode ? 1'($urandom % 2) : rdy_a;

    if (!bus_b.read_n && was_low_b && bus_b.r_addr == last_addr_b) age_b++;
    else age_b = 0;
    was_low_b       = !bus_b.read_n;
    last_addr_b     = bus_b.r_addr;
    bus_b.ry        = bus_b.read_n ? 1'($urandom % 2) : (age_b >= 1);
    bus_b.data_out  = 9'(bus_b.r_addr) + 9'd100;
    bus_b.out_ready = 1'b1;
  end

  // Monitor: every accepted read and every popped word is checked against the reference.
  always @(negedge clk) begin
    if (!rst) begin
      if (!bus_a.read_n && bus_a.ry) begin
        check_eq("addr_a", bus_a.r_addr, exp_addr(0, push_a));
        push_a++;
      end
      if (bus_a.out_valid && bus_a.out_ready) begin
        check_eq("data_a", bus_a.out_data, exp_word(0, pop_a));
        pop_a++;
      end
      if (done_a) done_cnt_a++;
      if (busy_a) busy_cyc_a++;
      if (!bus_a.read_n && bus_a.r_addr == 8'd3) low3_a++;
      if (!bus_b.read_n && bus_b.ry) begin
        check_eq("addr_b", bus_b.r_addr, exp_addr(250, push_b));
        push_b++;
      end
      if (bus_b.out_valid && bus_b.out_ready) begin
        check_eq("data_b", bus_b.out_data, exp_word(250, pop_b));
        pop_b++;
      end
      if (done_b) done_cnt_b++;
    end
  end

  task automatic pulse_start_a();
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic pulse_start_b();
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
  endtask

  task automatic wait_idle_a(input int max_cyc);
    int c = 0;
    while (busy_a && c < max_cyc) begin
      @(posedge clk); #1;
      c++;
    end
    check_eq("idle_a_bound", 32'(c < max_cyc), 32'd1);
  endtask

  task automatic wait_idle_b(input int max_cyc);
    int c = 0;
    while (busy_b && c < max_cyc) begin
      @(posedge clk); #1;
      c++;
    end
    check_eq("idle_b_bound", 32'(c < max_cyc), 32'd1);
  endtask

  initial begin
    bus_a.ry = 1'b0; bus_a.data_out = '0; bus_a.out_ready = 1'b0;
    bus_b.ry = 1'b0; bus_b.data_out = '0; bus_b.out_ready = 1'b0;
    clear_stats();

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_read_n", bus_a.read_n, 1);
    check_eq("rst_r_addr", bus_a.r_addr, 0);
    check_eq("rst_out_valid", bus_a.out_valid, 0);
    check_eq("rst_out_data", bus_a.out_data, 0);
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_done", done_a, 0);
    check_eq("rst_timeout_err", terr_a, 0);
    check_eq("rst_r_addr_b", bus_b.r_addr, 250);
    rst = 1'b0;
    @(posedge clk); #1;

    // Nominal pass
    clear_stats();
    pulse_start_a();
    wait_idle_a(200);
    check_eq("nom_pops", pop_a, 16);
    check_eq("nom_reads", push_a, 16);
    check_eq("nom_done", done_cnt_a, 1);
    check_eq("nom_terr", terr_a, 0);
    check_eq("nom_busy_cycles", busy_cyc_a, 35);

    // Backpressure: host stalled for the first 20 cycles
    rdy_a = 1'b0;
    clear_stats();
    pulse_start_a();
    repeat (19) begin @(posedge clk); #1; end
    check_eq("bp_reads", push_a, 4);
    check_eq("bp_read_n", bus_a.read_n, 1);
    check_eq("bp_valid", bus_a.out_valid, 1);
    rdy_a = 1'b1;
    wait_idle_a(200);
    check_eq("bp_pops", pop_a, 16);
    check_eq("bp_done", done_cnt_a, 1);

    // Timeout on address 3
    stuck_addr = 3;
    clear_stats();
    pulse_start_a();
    wait_idle_a(200);
    check_eq("to_terr", terr_a, 1);
    check_eq("to_pops", pop_a, 3);
    check_eq("to_reads", push_a, 3);
    check_eq("to_low_cycles", low3_a, 16);
    check_eq("to_done", done_cnt_a, 1);
    check_eq("to_busy", busy_a, 0);
    stuck_addr = -1;
    clear_stats();
    pulse_start_a();
    check_eq("to_clear", terr_a, 0);
    wait_idle_a(200);
    check_eq("to_next_pops", pop_a, 16);
    check_eq("to_next_terr", terr_a, 0);

    // Address wrap with a start pulse mid-pass
    clear_stats();
    pulse_start_b();
    repeat (5) begin @(posedge clk); #1; end
    pulse_start_b();
    wait_idle_b(200);
    check_eq("wrap_reads", push_b, 10);
    check_eq("wrap_pops", pop_b, 10);
    check_eq("wrap_done", done_cnt_b, 1);
    check_eq("wrap_terr", terr_b, 0);

    // Reset while waiting on word 5
    clear_stats();
    pulse_start_a();
    begin
      int c = 0;
      while (!(!bus_a.read_n && bus_a.r_addr == 8'd5) && c < 100) begin
        @(posedge clk); #1;
        c++;
      end
      check_eq("mid_reach_addr5", 32'(c < 100), 32'd1);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_eq("mid_read_n", bus_a.read_n, 1);
    check_eq("mid_r_addr", bus_a.r_addr, 0);
    check_eq("mid_out_valid", bus_a.out_valid, 0);
    check_eq("mid_busy", busy_a, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_stats();
    pulse_start_a();
    wait_idle_a(200);
    check_eq("mid_pops", pop_a, 16);
    check_eq("mid_done", done_cnt_a, 1);

    // Random latency and host stalls
    rand_mode = 1;
    for (int p = 0; p < 3; p++) begin
      clear_stats();
      pulse_start_a();
      wait_idle_a(600);
      check_eq("rnd_pops", pop_a, 16);
      check_eq("rnd_reads", push_a, 16);
      check_eq("rnd_done", done_cnt_a, 1);
      check_eq("rnd_terr", terr_a, 0);
    end
    rand_mode = 0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
